sprite_color_gen: RTL and testbench
===================================

SPRITE_COLOR_GEN -- requirements
Module: sprite_color_gen

Interface
REQ-001 The block SHALL have parameter ROWS, default 8, meaning number of matrix rows.
REQ-002 The block SHALL have parameter COLS, default 8, meaning columns per colour plane.
REQ-003 The block SHALL have parameter NCH, default 3, meaning number of colour planes.
REQ-004 The block SHALL have parameter LFSR_W, default 3, meaning LFSR width; legal range NCH..8.
REQ-005 The block SHALL have parameter HOLD, default 4, meaning clk_en ticks per displayed frame; legal range >=1.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 The block SHALL have port clk_en, input, 1 bit: frame-advance tick enable.
REQ-009 The block SHALL have port load, input, 1 bit: capture configuration and start display.
REQ-010 The block SHALL have port seed, input, LFSR_W bits: LFSR seed captured on load.
REQ-011 The block SHALL have port mode, input, 2 bits: 00 random, 01 sequential, 10 fixed, 11 blink; captured on load.
REQ-012 The block SHALL have port fixed_color, input, NCH bits: start or fixed colour code captured on load.
REQ-013 The block SHALL have port sprite, input, ROWS x COLS bits: bitmap captured on load.
REQ-014 The block SHALL have port out, output, ROWS x (NCH*COLS) bits: row r = {plane NCH-1 .. plane 0}, plane k = sprite_q[r] when color[k]=1, else 0.
REQ-015 The block SHALL have port color, output, NCH bits: current colour code.
REQ-016 The block SHALL have port frame_pulse, output, 1 bit: one-cycle strobe on each new frame.

Function
REQ-017 The block SHALL hold states IDLE, SHOW and BLANK; out SHALL be all-zero in IDLE and BLANK.
REQ-018 load SHALL capture seed, mode, fixed_color and sprite, clear hold_cnt and enter SHOW from any state; out, color and frame_pulse SHALL reflect the load in the cycle after the load edge.
REQ-019 On load, seed=0 SHALL load the LFSR with 1 (no lock-up).
REQ-020 The LFSR SHALL be Fibonacci, shift-left, new LSB = XOR of taps: W3 {2,1}; W4 {3,2}; W5 {4,2}; W6 {5,4}; W7 {6,5}; W8 {7,5,4,3}.
REQ-021 Initial colour on load SHALL be: random = LFSR[NCH-1:0] of the loaded value; sequential, fixed and blink = fixed_color.
REQ-022 Any computed colour code of 0 SHALL be replaced by 1.
REQ-023 In SHOW or BLANK, each clk_en=1 cycle SHALL increment hold_cnt; at hold_cnt=HOLD-1 it SHALL wrap to 0 and the frame SHALL advance.
REQ-024 Random-mode advance SHALL step the LFSR once, with color = new LFSR[NCH-1:0].
REQ-025 Sequential-mode advance SHALL set color = color+1, wrapping 2^NCH-1 to 1.
REQ-026 Fixed-mode advance SHALL leave color unchanged.
REQ-027 Blink-mode advance SHALL toggle SHOW<->BLANK with color unchanged.
REQ-028 frame_pulse SHALL be high for exactly one cycle after each load and after each advance that enters or stays in SHOW; it SHALL be 0 on entry to BLANK.
REQ-029 With clk_en=0, all state, hold_cnt, LFSR and outputs SHALL hold.
REQ-030 load and an advance in the same cycle SHALL resolve as load only.
REQ-031 mode, seed, fixed_color and sprite changes without load SHALL have no effect.

Reset
REQ-032 rst_n=0 SHALL immediately set state IDLE, out=0, color=0, frame_pulse=0, hold_cnt=0, LFSR=1 and sprite_q=0, independent of clk.
REQ-033 Reset asserted mid-frame SHALL abort the frame; after release the block SHALL stay IDLE until load.

Verification (NCH=3, LFSR_W=3, HOLD=2, sprite row7=8'h3C)
REQ-034 Assert rst_n=0 mid-cycle -> out=0, color=0 and frame_pulse=0 immediately; block stays IDLE after release with clk_en toggling.
REQ-035 load with seed=001, mode=00, clk_en=1 held -> color sequence 001,010,101,011,111,110,100,001 every 2 cycles; out[7] starts 24'h00003C, then 24'h003C00, then 24'h3C003C.
REQ-036 load with seed=000, mode=00 -> color=001 and frame_pulse=1 in the next cycle.
REQ-037 load with mode=01, fixed_color=110 -> colors 110,111,001,010; fixed_color=000 -> start color 001.
REQ-038 load with mode=11, fixed_color=100 -> out[7] alternates 24'h3C0000 and 0 every 2 ticks; clk_en=0 freezes out; frame_pulse=1 only on SHOW entries.
REQ-039 load coincident with hold expiry -> load result only; color=fixed_color (mode 01), hold_cnt restarts from 0.

Source files
------------

// File: rtl/sprite_color_gen.sv
// Sprite colour generator: captures a bitmap and spreads it over NCH colour
// planes, advancing the colour (random/sequential/fixed/blink) every HOLD ticks.
module sprite_color_gen #(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int NCH    = 3,
    parameter int LFSR_W = 3,
    parameter int HOLD   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clk_en,
    input  logic                       load,
    input  logic [LFSR_W-1:0]          seed,
    input  logic [1:0]                 mode,
    input  logic [NCH-1:0]             fixed_color,
    input  logic [ROWS*COLS-1:0]       sprite,
    output logic [ROWS*NCH*COLS-1:0]   out,
    output logic [NCH-1:0]             color,
    output logic                       frame_pulse
);

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [1:0] M_RAND  = 2'b00;
    localparam logic [1:0] M_SEQ   = 2'b01;
    localparam logic [1:0] M_FIXED = 2'b10;
    localparam logic [1:0] M_BLINK = 2'b11;

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

    state_t                 r_state;
    logic [HW-1:0]          r_hold;
    logic [LFSR_W-1:0]      r_lfsr;
    logic [1:0]             r_mode;
    logic [ROWS*COLS-1:0]   r_sprite;
    logic [NCH-1:0]         r_color;
    logic                   r_pulse;

    logic [LFSR_W-1:0]      w_seed;
    logic [LFSR_W-1:0]      w_next;
    logic                   w_last;

    function automatic logic [LFSR_W-1:0] f_step(input logic [LFSR_W-1:0] v);
        logic [7:0] x;
        logic       fb;
        x = 8'(v);
        case (LFSR_W)
            3:       fb = x[2] ^ x[1];
            4:       fb = x[3] ^ x[2];
            5:       fb = x[4] ^ x[2];
            6:       fb = x[5] ^ x[4];
            7:       fb = x[6] ^ x[5];
            default: fb = x[7] ^ x[5] ^ x[4] ^ x[3];
        endcase
        return {v[LFSR_W-2:0], fb};
    endfunction

    // A colour code of zero would blank the sprite, so it is never produced.
    function automatic logic [NCH-1:0] f_nz(input logic [NCH-1:0] c);
        return (c == '0) ? NCH'(1) : c;
    endfunction

    assign w_seed = (seed == '0) ? LFSR_W'(1) : seed;
    assign w_next = f_step(r_lfsr);
    assign w_last = (r_hold == HW'(HOLD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_hold   <= '0;
            r_lfsr   <= LFSR_W'(1);
            r_mode   <= M_RAND;
            r_sprite <= '0;
            r_color  <= '0;
            r_pulse  <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (load) begin
                r_sprite <= sprite;
                r_mode   <= mode;
                r_hold   <= '0;
                r_state  <= SHOW;
                r_pulse  <= 1'b1;
                r_lfsr   <= w_seed;
                r_color  <= (mode == M_RAND) ? f_nz(w_seed[NCH-1:0])
                                             : f_nz(fixed_color);
            end else if (clk_en && r_state != IDLE) begin
                if (w_last) begin
                    r_hold <= '0;
                    case (r_mode)
                        M_RAND: begin
                            r_lfsr  <= w_next;
                            r_color <= f_nz(w_next[NCH-1:0]);
                            r_pulse <= 1'b1;
                        end
                        M_SEQ: begin
                            r_color <= f_nz(r_color + NCH'(1));
                            r_pulse <= 1'b1;
                        end
                        M_FIXED: begin
                            r_pulse <= 1'b1;
                        end
                        M_BLINK: begin
                            r_state <= (r_state == SHOW) ? BLANK : SHOW;
                            r_pulse <= (r_state == BLANK);
                        end
                        default: ;
                    endcase
                end else begin
                    r_hold <= r_hold + HW'(1);
                end
            end
        end
    end

    always_comb begin
        out = '0;
        if (r_state == SHOW) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int k = 0; k < NCH; k++) begin
                    if (r_color[k])
                        out[r*NCH*COLS + k*COLS +: COLS] = r_sprite[r*COLS +: COLS];
                end
            end
        end
    end

    assign color       = r_color;
    assign frame_pulse = r_pulse;

endmodule

// File: tb/tb_sprite_color_gen.sv
// Bench for sprite_color_gen: directed vector table, reset checks and
// randomized traffic against a sequence-table reference model.
module tb_sprite_color_gen;

    localparam int ROWS = 8, COLS = 8, NCH = 3, LW = 3, HOLD = 2;
    localparam int OW = ROWS * NCH * COLS;

    logic                 clk = 0;
    logic                 rst_n = 0;
    logic                 clk_en = 0;
    logic                 load = 0;
    logic [LW-1:0]        seed = '0;
    logic [1:0]           mode = '0;
    logic [NCH-1:0]       fixed_color = '0;
    logic [ROWS*COLS-1:0] sprite = '0;
    logic [OW-1:0]        out;
    logic [NCH-1:0]       color;
    logic                 frame_pulse;

    sprite_color_gen #(
        .ROWS(ROWS), .COLS(COLS), .NCH(NCH), .LFSR_W(LW), .HOLD(HOLD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .load(load),
        .seed(seed), .mode(mode), .fixed_color(fixed_color),
        .sprite(sprite), .out(out), .color(color),
        .frame_pulse(frame_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [OW-1:0] act,
                       input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: the 3-bit maximal-length sequence as a table.
    int seq[7] = '{1, 2, 5, 3, 7, 6, 4};
    int m_st, m_hold, m_idx, m_color, m_pulse, m_mode;
    logic [ROWS*COLS-1:0] m_spr;

    function automatic int nz(input int c);
        return (c == 0) ? 1 : c;
    endfunction

    task automatic m_reset();
        m_st = 0; m_hold = 0; m_idx = 0; m_color = 0;
        m_pulse = 0; m_mode = 0; m_spr = '0;
    endtask

    task automatic m_edge();
        int s;
        if (!rst_n) return;
        m_pulse = 0;
        if (load) begin
            m_spr = sprite; m_mode = mode; m_hold = 0; m_st = 1; m_pulse = 1;
            s = (seed == 0) ? 1 : int'(seed);
            for (int i = 0; i < 7; i++) if (seq[i] == s) m_idx = i;
            m_color = (mode == 0) ? nz(seq[m_idx]) : nz(int'(fixed_color));
        end else if (clk_en && m_st != 0) begin
            m_hold++;
            if (m_hold == HOLD) begin
                m_hold = 0;
                case (m_mode)
                    0: begin m_idx = (m_idx + 1) % 7; m_color = seq[m_idx]; m_pulse = 1; end
                    1: begin m_color = (m_color == 7) ? 1 : m_color + 1; m_pulse = 1; end
                    2: m_pulse = 1;
                    default: begin m_st = (m_st == 1) ? 2 : 1; m_pulse = (m_st == 1); end
                endcase
            end
        end
    endtask

    function automatic logic [OW-1:0] m_out();
        logic [OW-1:0] o;
        o = '0;
        if (m_st == 1)
            for (int r = 0; r < ROWS; r++)
                for (int k = 0; k < NCH; k++)
                    if (m_color[k]) o[r*NCH*COLS + k*COLS +: COLS] = m_spr[r*COLS +: COLS];
        return o;
    endfunction

    task automatic cyc();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    typedef struct {
        logic ld; logic en; logic [2:0] sd; logic [1:0] md; logic [2:0] fc;
        logic [2:0] ec; logic ep; logic [23:0] er;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(logic ld, logic en, logic [2:0] sd,
                                logic [1:0] md, logic [2:0] fc, logic [2:0] ec,
                                logic ep, logic [23:0] er);
        vec_t v;
        v.ld = ld; v.en = en; v.sd = sd; v.md = md; v.fc = fc;
        v.ec = ec; v.ep = ep; v.er = er;
        return v;
    endfunction

    initial begin
        logic [OW-1:0] exp_out;
        m_reset();
        sprite = {8'h3C, 56'h0};

        // random colour sequence
        tbl.push_back(mk(1, 1, 3'b001, 2'b00, 0, 3'b001, 1, 24'h00003C));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3'b001, 0, 24'h00003C));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3'b010, 1, 24'h003C00));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3'b010, 0, 24'h003C00));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3'b101, 1, 24'h3C003C));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3'b101, 0, 24'h3C003C));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3'b011, 1, 24'h003C3C));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3'b011, 0, 24'h003C3C));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3'b111, 1, 24'h3C3C3C));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3'b111, 0, 24'h3C3C3C));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3'b110, 1, 24'h3C3C00));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3'b110, 0, 24'h3C3C00));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3'b100, 1, 24'h3C0000));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3'b100, 0, 24'h3C0000));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3'b001, 1, 24'h00003C));
        // zero seed
        tbl.push_back(mk(1, 0, 3'b000, 2'b00, 3'b110, 3'b001, 1, 24'h00003C));
        // sequential
        tbl.push_back(mk(1, 1, 0, 2'b01, 3'b110, 3'b110, 1, 24'h3C3C00));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3'b110, 0, 24'h3C3C00));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3'b111, 1, 24'h3C3C3C));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3'b111, 0, 24'h3C3C3C));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3'b001, 1, 24'h00003C));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3'b001, 0, 24'h00003C));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3'b010, 1, 24'h003C00));
        tbl.push_back(mk(1, 0, 0, 2'b01, 3'b000, 3'b001, 1, 24'h00003C));
        // blink with a freeze
        tbl.push_back(mk(1, 1, 0, 2'b11, 3'b100, 3'b100, 1, 24'h3C0000));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3'b100, 0, 24'h3C0000));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3'b100, 0, 24'h000000));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3'b100, 0, 24'h000000));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3'b100, 1, 24'h3C0000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3'b100, 0, 24'h3C0000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3'b100, 0, 24'h3C0000));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3'b100, 0, 24'h3C0000));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3'b100, 0, 24'h000000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3'b100, 0, 24'h000000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3'b100, 0, 24'h000000));
        // load coincident with hold expiry
        tbl.push_back(mk(1, 1, 0, 2'b01, 3'b011, 3'b011, 1, 24'h003C3C));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3'b011, 0, 24'h003C3C));
        tbl.push_back(mk(1, 1, 0, 2'b01, 3'b101, 3'b101, 1, 24'h3C003C));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3'b101, 0, 24'h3C003C));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3'b110, 1, 24'h3C3C00));

        #2;
        chk("reset_color", OW'(color), '0);
        chk("reset_pulse", OW'(frame_pulse), '0);
        chk("reset_out", out, '0);
        @(negedge clk) rst_n = 1;

        foreach (tbl[i]) begin
            @(negedge clk);
            load = tbl[i].ld; clk_en = tbl[i].en;
            if (tbl[i].ld) begin
                seed = tbl[i].sd; mode = tbl[i].md; fixed_color = tbl[i].fc;
            end else begin
                seed = 3'($urandom); mode = 2'($urandom); fixed_color = 3'($urandom);
            end
            cyc();
            chk($sformatf("vec%0d_color", i), OW'(color), OW'(tbl[i].ec));
            chk($sformatf("vec%0d_pulse", i), OW'(frame_pulse), OW'(tbl[i].ep));
            chk($sformatf("vec%0d_out", i), out, {tbl[i].er, 168'h0});
        end

        // asynchronous reset mid-cycle, then stay idle without load
        @(negedge clk);
        load = 0; clk_en = 1;
        @(posedge clk); m_edge();
        #2 rst_n = 0; m_reset();
        #1;
        chk("async_rst_out", out, '0);
        chk("async_rst_color", OW'(color), '0);
        chk("async_rst_pulse", OW'(frame_pulse), '0);
        @(negedge clk) rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk) clk_en = i[0];
            cyc();
            chk("idle_out", out, '0);
            chk("idle_color", OW'(color), '0);
            chk("idle_pulse", OW'(frame_pulse), '0);
        end

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            load = ($urandom_range(0, 9) == 0);
            clk_en = ($urandom_range(0, 3) != 0);
            seed = 3'($urandom); mode = 2'($urandom);
            fixed_color = 3'($urandom);
            sprite = {$urandom, $urandom};
            if (i == 300) begin
                #2 rst_n = 0; m_reset();
                #1;
                chk("rnd_rst_out", out, '0);
                @(negedge clk) rst_n = 1;
            end
            cyc();
            exp_out = m_out();
            chk("rnd_color", OW'(color), OW'(m_color));
            chk("rnd_pulse", OW'(frame_pulse), OW'(m_pulse));
            chk("rnd_out", out, exp_out);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
